// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit: FSM state encoding and
// default parameter values.
package hazard_control_unit_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } hcu_state_t;

  localparam int DEFAULT_MUL_LATENCY = 4;
  localparam int DEFAULT_CNT_W       = 16;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous reset. It counts one step per
// enabled edge and holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stall, branch/jump flush and multi-cycle
// multiply hold, plus a saturating count of stalled cycles.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs_i,
  input  logic [4:0]       ID_rt_i,
  input  logic             ID_mul_i,
  input  logic             ID_branch_taken_i,
  input  logic             ID_jump_i,
  input  logic [4:0]       ID_EX_rt_i,
  input  logic             ID_EX_MemRead_i,
  output logic             PC_write_o,
  output logic             IF_ID_write_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_write_o,
  output logic             ID_EX_bubble_o,
  output logic             EX_MEM_bubble_o,
  output logic             state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // The first wait cycle overlaps the reload, so the counter starts at latency-2.
  localparam logic [3:0] MUL_RELOAD = (MUL_LATENCY > 1) ? 4'(MUL_LATENCY - 2) : 4'd0;

  hcu_state_t state;
  logic [3:0] mul_cnt;
  logic       load_use;
  logic       redirect;
  logic       mul_entry;

  assign load_use  = ID_EX_MemRead_i && (ID_EX_rt_i != 5'd0) &&
                     ((ID_EX_rt_i == ID_rs_i) || (ID_EX_rt_i == ID_rt_i));
  assign redirect  = ID_branch_taken_i || ID_jump_i;
  assign mul_entry = (state == RUN) && !load_use && !redirect && ID_mul_i &&
                     (MUL_LATENCY > 1);

  always_comb begin
    PC_write_o      = 1'b1;
    IF_ID_write_o   = 1'b1;
    ID_EX_write_o   = 1'b1;
    IF_ID_flush_o   = 1'b0;
    ID_EX_bubble_o  = 1'b0;
    EX_MEM_bubble_o = 1'b0;
    if (state == MUL_WAIT) begin
      PC_write_o      = 1'b0;
      IF_ID_write_o   = 1'b0;
      ID_EX_write_o   = 1'b0;
      EX_MEM_bubble_o = 1'b1;
    end else if (load_use) begin
      PC_write_o     = 1'b0;
      IF_ID_write_o  = 1'b0;
      ID_EX_bubble_o = 1'b1;
    end else if (redirect) begin
      IF_ID_flush_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      mul_cnt <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (mul_entry) begin
            state   <= MUL_WAIT;
            mul_cnt <= MUL_RELOAD;
          end
        end
        MUL_WAIT: begin
          if (mul_cnt == 4'd0) begin
            state <= RUN;
          end else begin
            mul_cnt <= mul_cnt - 4'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign state_o = state;

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (!PC_write_o),
    .count(stall_cnt_o)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: a default instance plus a small one
// (MUL_LATENCY=1, CNT_W=4) for the single-cycle multiply and saturation cases.
`timescale 1ns/1ps
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_rs_i, ID_rt_i, ID_EX_rt_i;
  logic        ID_mul_i, ID_branch_taken_i, ID_jump_i, ID_EX_MemRead_i;

  logic        PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_write_o;
  logic        ID_EX_bubble_o, EX_MEM_bubble_o, state_o;
  logic [15:0] stall_cnt_o;

  logic        s_PC_write_o, s_IF_ID_write_o, s_IF_ID_flush_o, s_ID_EX_write_o;
  logic        s_ID_EX_bubble_o, s_EX_MEM_bubble_o, s_state_o;
  logic [3:0]  s_stall_cnt_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_cnt      = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.MUL_LATENCY(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .ID_rs_i(ID_rs_i), .ID_rt_i(ID_rt_i), .ID_mul_i(ID_mul_i),
    .ID_branch_taken_i(ID_branch_taken_i), .ID_jump_i(ID_jump_i),
    .ID_EX_rt_i(ID_EX_rt_i), .ID_EX_MemRead_i(ID_EX_MemRead_i),
    .PC_write_o(PC_write_o), .IF_ID_write_o(IF_ID_write_o),
    .IF_ID_flush_o(IF_ID_flush_o), .ID_EX_write_o(ID_EX_write_o),
    .ID_EX_bubble_o(ID_EX_bubble_o), .EX_MEM_bubble_o(EX_MEM_bubble_o),
    .state_o(state_o), .stall_cnt_o(stall_cnt_o)
  );

  hazard_control_unit #(.MUL_LATENCY(1), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset),
    .ID_rs_i(ID_rs_i), .ID_rt_i(ID_rt_i), .ID_mul_i(ID_mul_i),
    .ID_branch_taken_i(ID_branch_taken_i), .ID_jump_i(ID_jump_i),
    .ID_EX_rt_i(ID_EX_rt_i), .ID_EX_MemRead_i(ID_EX_MemRead_i),
    .PC_write_o(s_PC_write_o), .IF_ID_write_o(s_IF_ID_write_o),
    .IF_ID_flush_o(s_IF_ID_flush_o), .ID_EX_write_o(s_ID_EX_write_o),
    .ID_EX_bubble_o(s_ID_EX_bubble_o), .EX_MEM_bubble_o(s_EX_MEM_bubble_o),
    .state_o(s_state_o), .stall_cnt_o(s_stall_cnt_o)
  );

  task automatic set_idle();
    ID_rs_i = 5'd0; ID_rt_i = 5'd0; ID_EX_rt_i = 5'd0;
    ID_mul_i = 1'b0; ID_branch_taken_i = 1'b0; ID_jump_i = 1'b0;
    ID_EX_MemRead_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // RUN with no event: all load enables high, nothing bubbled or flushed.
  task automatic check_run_idle(input string name);
    tests_run++;
    if ({PC_write_o, IF_ID_write_o, ID_EX_write_o, IF_ID_flush_o, ID_EX_bubble_o, EX_MEM_bubble_o, state_o} !== 7'b1110000) begin
      tests_failed++;
      $display("[TB] FAIL %s: pc/ifid/idex/flush/idbub/exbub/state got %b expected 1110000", name,
               {PC_write_o, IF_ID_write_o, ID_EX_write_o, IF_ID_flush_o, ID_EX_bubble_o, EX_MEM_bubble_o, state_o});
    end
  endtask

  task automatic check_cnt(input string name);
    tests_run++;
    if (stall_cnt_o !== 16'(exp_cnt)) begin
      tests_failed++;
      $display("[TB] FAIL %s: stall_cnt_o got %0d expected %0d", name, stall_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    exp_cnt = 0;
    #1;
    check_run_idle("reset_outputs");
    check_cnt("reset_cnt");
    next_cycle();
    check_cnt("idle_no_count");
  endtask

  task automatic test_load_use();
    ID_EX_MemRead_i = 1'b1; ID_EX_rt_i = 5'd8; ID_rs_i = 5'd8; ID_rt_i = 5'd3;
    #1;
    tests_run++;
    if ({PC_write_o, IF_ID_write_o, ID_EX_write_o, ID_EX_bubble_o, IF_ID_flush_o} !== 5'b00110) begin
      tests_failed++;
      $display("[TB] FAIL load_use_rs: pc/ifid/idex/idbub/flush got %b expected 00110",
               {PC_write_o, IF_ID_write_o, ID_EX_write_o, ID_EX_bubble_o, IF_ID_flush_o});
    end
    next_cycle();
    exp_cnt = 1;
    check_cnt("load_use_cnt_1");
    tests_run++;
    if (state_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_use_state: state_o got %b expected 0", state_o);
    end
    ID_EX_rt_i = 5'd5; ID_rs_i = 5'd3; ID_rt_i = 5'd5;
    #1;
    tests_run++;
    if ({PC_write_o, ID_EX_bubble_o} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL load_use_rt: pc/idbub got %b expected 01", {PC_write_o, ID_EX_bubble_o});
    end
    next_cycle();
    exp_cnt = 2;
    check_cnt("load_use_cnt_2");
    set_idle();
    #1;
    check_run_idle("load_use_release");
  endtask

  task automatic test_no_hazard();
    ID_EX_MemRead_i = 1'b1; ID_EX_rt_i = 5'd0; ID_rs_i = 5'd0; ID_rt_i = 5'd0;
    #1;
    check_run_idle("zero_reg_no_stall");
    ID_EX_MemRead_i = 1'b0; ID_EX_rt_i = 5'd8; ID_rs_i = 5'd8;
    #1;
    check_run_idle("no_memread_no_stall");
    ID_EX_MemRead_i = 1'b1; ID_EX_rt_i = 5'd9; ID_rs_i = 5'd8; ID_rt_i = 5'd10;
    #1;
    check_run_idle("mismatch_no_stall");
    next_cycle();
    check_cnt("no_hazard_cnt");
    set_idle();
  endtask

  task automatic test_branch_jump();
    ID_branch_taken_i = 1'b1;
    #1;
    tests_run++;
    if ({PC_write_o, IF_ID_write_o, ID_EX_write_o, IF_ID_flush_o, ID_EX_bubble_o} !== 5'b11110) begin
      tests_failed++;
      $display("[TB] FAIL branch_flush: pc/ifid/idex/flush/idbub got %b expected 11110",
               {PC_write_o, IF_ID_write_o, ID_EX_write_o, IF_ID_flush_o, ID_EX_bubble_o});
    end
    ID_branch_taken_i = 1'b0; ID_jump_i = 1'b1;
    #1;
    tests_run++;
    if ({PC_write_o, IF_ID_flush_o} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL jump_flush: pc/flush got %b expected 11", {PC_write_o, IF_ID_flush_o});
    end
    next_cycle();
    check_cnt("jump_cnt");
    set_idle();
    #1;
    check_run_idle("jump_release");
  endtask

  task automatic test_multiply();
    ID_mul_i = 1'b1;
    #1;
    check_run_idle("mul_entry_cycle");
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      // ID-stage events during the wait must have no effect.
      ID_mul_i = 1'b1; ID_branch_taken_i = 1'b1;
      ID_EX_MemRead_i = 1'b1; ID_EX_rt_i = 5'd4; ID_rs_i = 5'd4;
      #1;
      tests_run++;
      if ({state_o, PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_bubble_o, IF_ID_flush_o, ID_EX_bubble_o} !== 7'b1000100) begin
        tests_failed++;
        $display("[TB] FAIL mul_wait_%0d: state/pc/ifid/idex/exbub/flush/idbub got %b expected 1000100", i,
                 {state_o, PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_bubble_o, IF_ID_flush_o, ID_EX_bubble_o});
      end
      if (i == 2) set_idle();
      next_cycle();
    end
    exp_cnt = 5;
    check_run_idle("mul_return_run");
    check_cnt("mul_cnt_plus3");
  endtask

  task automatic test_priority();
    ID_EX_MemRead_i = 1'b1; ID_EX_rt_i = 5'd8; ID_rs_i = 5'd8;
    ID_branch_taken_i = 1'b1; ID_mul_i = 1'b1;
    #1;
    tests_run++;
    if ({PC_write_o, ID_EX_bubble_o, IF_ID_flush_o} !== 3'b010) begin
      tests_failed++;
      $display("[TB] FAIL prio_load_use: pc/idbub/flush got %b expected 010", {PC_write_o, ID_EX_bubble_o, IF_ID_flush_o});
    end
    next_cycle();
    exp_cnt = 6;
    check_cnt("prio_cnt");
    ID_EX_MemRead_i = 1'b0;
    #1;
    tests_run++;
    if ({PC_write_o, IF_ID_flush_o, ID_EX_bubble_o, state_o} !== 4'b1100) begin
      tests_failed++;
      $display("[TB] FAIL prio_flush: pc/flush/idbub/state got %b expected 1100",
               {PC_write_o, IF_ID_flush_o, ID_EX_bubble_o, state_o});
    end
    next_cycle();
    set_idle();
    #1;
    tests_run++;
    if (state_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL prio_no_mul_wait: state_o got %b expected 0", state_o);
    end
    check_cnt("prio_cnt_hold");
  endtask

  task automatic test_reset_in_wait();
    ID_mul_i = 1'b1;
    next_cycle();
    set_idle();
    next_cycle();
    tests_run++;
    if (state_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wait_before_reset: state_o got %b expected 1", state_o);
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    exp_cnt = 0;
    #1;
    check_run_idle("reset_abort_wait");
    check_cnt("reset_abort_cnt");
  endtask

  task automatic test_mul_latency1();
    ID_mul_i = 1'b1;
    #1;
    tests_run++;
    if ({s_PC_write_o, s_EX_MEM_bubble_o} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL lat1_entry: pc/exbub got %b expected 10", {s_PC_write_o, s_EX_MEM_bubble_o});
    end
    next_cycle();
    tests_run++;
    if ({s_state_o, s_PC_write_o, s_stall_cnt_o} !== 6'b010000) begin
      tests_failed++;
      $display("[TB] FAIL lat1_no_wait: state/pc/cnt got %b expected 010000", {s_state_o, s_PC_write_o, s_stall_cnt_o});
    end
    set_idle();
  endtask

  task automatic test_saturate();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    ID_EX_MemRead_i = 1'b1; ID_EX_rt_i = 5'd7; ID_rt_i = 5'd7;
    for (int i = 0; i < 14; i++) next_cycle();
    tests_run++;
    if (s_stall_cnt_o !== 4'd14) begin
      tests_failed++;
      $display("[TB] FAIL sat_before_top: stall_cnt_o got %0d expected 14", s_stall_cnt_o);
    end
    for (int i = 0; i < 6; i++) next_cycle();
    tests_run++;
    if (s_stall_cnt_o !== 4'd15) begin
      tests_failed++;
      $display("[TB] FAIL sat_hold: stall_cnt_o got %0d expected 15", s_stall_cnt_o);
    end
    exp_cnt = 20;
    check_cnt("wide_cnt_20");
    set_idle();
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    #1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_jump();
    test_multiply();
    test_priority();
    test_reset_in_wait();
    test_mul_latency1();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter MUL_LATENCY, default 4, meaning EX-stage occupancy of a multiply in cycles (legal 1..15).
REQ-002 Parameter CNT_W, default 16, meaning width of the stall performance counter.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ID_rs_i  input  5  rs field of the instruction in ID.
REQ-006 ID_rt_i  input  5  rt field of the instruction in ID.
REQ-007 ID_mul_i  input  1  instruction in ID is a multiply.
REQ-008 ID_branch_taken_i  input  1  branch in ID resolved taken.
REQ-009 ID_jump_i  input  1  jump in ID.
REQ-010 ID_EX_rt_i  input  5  destination rt of the instruction in EX.
REQ-011 ID_EX_MemRead_i  input  1  instruction in EX is a load.
REQ-012 PC_write_o  output  1  PC load enable.
REQ-013 IF_ID_write_o  output  1  IF/ID register load enable.
REQ-014 IF_ID_flush_o  output  1  clear IF/ID to NOP at the next edge.
REQ-015 ID_EX_write_o  output  1  ID/EX register load enable.
REQ-016 ID_EX_bubble_o  output  1  load NOP control word into ID/EX.
REQ-017 EX_MEM_bubble_o  output  1  load NOP control word into EX/MEM.
REQ-018 state_o  output  1  current state (0 RUN, 1 MUL_WAIT).
REQ-019 stall_cnt_o  output  CNT_W  registered count of stalled cycles.

Function
REQ-020 load_use SHALL be ID_EX_MemRead_i AND ID_EX_rt_i != 0 AND (ID_EX_rt_i == ID_rs_i OR ID_EX_rt_i == ID_rt_i).
REQ-021 Two states, RUN and MUL_WAIT, plus a 4-bit down-counter mul_cnt.
REQ-022 RUN, no event: PC_write_o=1, IF_ID_write_o=1, ID_EX_write_o=1, all bubble/flush outputs 0.
REQ-023 RUN, load_use: same cycle PC_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=1; state stays RUN.
REQ-024 RUN, !load_use and (ID_branch_taken_i or ID_jump_i): IF_ID_flush_o=1, other outputs as REQ-022.
REQ-025 RUN, !load_use and ID_mul_i and MUL_LATENCY>1: outputs as REQ-022; next state MUL_WAIT, mul_cnt loads MUL_LATENCY-2.
REQ-026 MUL_WAIT: PC_write_o=0, IF_ID_write_o=0, ID_EX_write_o=0, EX_MEM_bubble_o=1, IF_ID_flush_o=0, ID_EX_bubble_o=0; all ID-stage inputs ignored.
REQ-027 MUL_WAIT: mul_cnt==0 -> RUN next edge, else decrement; total MUL_WAIT cycles = MUL_LATENCY-1.
REQ-028 MUL_LATENCY==1: MUL_WAIT never entered.
REQ-029 Priority in RUN: load_use > branch/jump flush > multiply entry; a suppressed event is re-evaluated next cycle.
REQ-030 Branch/jump and ID_mul_i together: flush wins, no MUL_WAIT entry.
REQ-031 stall_cnt_o increments by 1 at each edge where PC_write_o==0; saturates at all-ones, never wraps.
REQ-032 All outputs except state_o and stall_cnt_o are combinational from state and inputs; no same-cycle latency added.

Reset
REQ-033 reset=1 at an edge: state RUN, mul_cnt 0, stall_cnt_o 0, regardless of current state.
REQ-034 Reset during MUL_WAIT aborts the wait; first post-reset cycle shows RUN outputs.
REQ-035 reset has priority over every transition and counter update in the same cycle.

Structure
REQ-036 Shared package holds state encoding (RUN=0, MUL_WAIT=1), MUL_LATENCY default, CNT_W default.
REQ-037 One sub-module, sat_counter (parameterised width, synchronous reset, increment enable, saturating), implements stall_cnt_o.

Verification
REQ-038 ID_EX_MemRead_i=1, ID_EX_rt_i=8, ID_rs_i=8 -> one cycle PC_write_o=0, ID_EX_bubble_o=1; stall_cnt_o 0->1.
REQ-039 ID_EX_MemRead_i=1, ID_EX_rt_i=0, ID_rt_i=0 -> no stall, PC_write_o=1.
REQ-040 MUL_LATENCY=4, ID_mul_i=1 in RUN -> exactly 3 MUL_WAIT cycles with EX_MEM_bubble_o=1, then RUN; stall_cnt_o +3.
REQ-041 load_use, ID_branch_taken_i and ID_mul_i together -> stall only, IF_ID_flush_o=0; next cycle (no load_use) flush=1, no MUL_WAIT.
REQ-042 reset=1 on second MUL_WAIT cycle -> next cycle state_o=0, stall_cnt_o=0, PC_write_o=1.
REQ-043 CNT_W=4, 20 forced stall cycles -> stall_cnt_o holds 15.
